lock_controller: RTL and testbench
==================================

LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter DIGITS, default 4: number of 4-bit digits per code; SHALL match the combination datapath code width.
REQ-002 Parameter MAX_TRIES, default 3: consecutive failed attempts before lockout.
REQ-003 Parameter UNLOCK_CYCLES, default 50_000_000: open-window duration in CLK cycles.
REQ-004 Parameter LOCKOUT_CYCLES, default 250_000_000: lockout duration in CLK cycles.
REQ-005 CLK  in  1  single system clock, all state on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-low.
REQ-007 Validate  in  1  one-cycle digit-strobe, same strobe the datapath sees.
REQ-008 Enter  in  1  one-cycle submit request.
REQ-009 ChangeCode  in  1  one-cycle request to program a new code, honoured only while open.
REQ-010 Pass  in  1  datapath: entered code equals stored code.
REQ-011 Reverse  in  1  datapath: entered code equals stored code digit-reversed.
REQ-012 ShiftA  out  1  enable entry-register shifting.
REQ-013 ShiftB  out  1  enable stored-code shifting.
REQ-014 RSTA  out  1  clear entry register.
REQ-015 Unlocked  out  1  lock open.
REQ-016 Alarm  out  1  duress alarm, sticky.
REQ-017 LockedOut  out  1  lockout active.
REQ-018 DigitCount  out  $clog2(DIGITS+1)  digits accepted in current entry.

Function
REQ-019 States SHALL be CLEAR, IDLE, ENTRY, CHECK, OPEN, NEWCODE, LOCKOUT, DURESS; outputs decoded from registered state and counters (Moore).
REQ-020 CLEAR: RSTA=1, ShiftA=ShiftB=0, DigitCount loaded 0, inputs ignored; exactly one cycle, then IDLE.
REQ-021 IDLE/ENTRY: ShiftA=1 iff DigitCount<DIGITS; each Validate with DigitCount<DIGITS increments DigitCount; first Validate moves IDLE->ENTRY.
REQ-022 Validate with DigitCount==DIGITS SHALL be ignored (ShiftA already 0, no count change).
REQ-023 Enter, judged on DigitCount at cycle start: ==DIGITS -> CHECK; <DIGITS -> CLEAR, no failure counted; Validate in same cycle still counted only if DigitCount<DIGITS and state goes CLEAR.
REQ-024 CHECK: one cycle, samples Pass/Reverse; Pass=1 -> OPEN, fail counter cleared (Pass wins over Reverse for palindromic codes); Pass=0,Reverse=1 -> DURESS, fail counter cleared; else fail counter +1, -> LOCKOUT if it reaches MAX_TRIES, otherwise CLEAR.
REQ-025 OPEN: Unlocked=1 for UNLOCK_CYCLES cycles, then CLEAR; ChangeCode -> NEWCODE with DigitCount=0.
REQ-026 NEWCODE: Unlocked=1, ShiftB=1 iff DigitCount<DIGITS; each Validate increments; at DigitCount==DIGITS -> CLEAR next cycle; Enter/ChangeCode ignored; no timeout.
REQ-027 LOCKOUT: LockedOut=1, all inputs ignored for LOCKOUT_CYCLES cycles, then CLEAR with fail counter cleared.
REQ-028 DURESS: Unlocked=1 for UNLOCK_CYCLES cycles, then CLEAR; Alarm set on entry and held until RST.
REQ-029 Timers SHALL count exactly N cycles from state entry (N=1 gives a one-cycle state); ShiftA and ShiftB SHALL never be 1 simultaneously.

Reset
REQ-030 RST low SHALL asynchronously force state CLEAR, DigitCount=0, fail counter=0, timer=0, Alarm=0; hence RSTA=1 and all other outputs 0 during and first cycle after reset.
REQ-031 Reset mid-NEWCODE SHALL abandon programming; stored-code content is the datapath's responsibility.

Structure
REQ-032 Package lock_pkg SHALL hold the state enumeration and default parameter constants.
REQ-033 One sub-module lock_timer (loadable down-counter, expire flag) SHALL be shared by OPEN, DURESS and LOCKOUT.

Verification
REQ-034 DIGITS=4, UNLOCK_CYCLES=8: enter 1,2,3,4 with stored 0x1234, Enter -> CHECK then Unlocked=1 exactly 8 cycles, then RSTA pulse.
REQ-035 Enter 4,3,2,1 -> DURESS: Unlocked=1 and Alarm=1; Alarm remains 1 after return to IDLE until RST.
REQ-036 MAX_TRIES=3, LOCKOUT_CYCLES=16: three wrong codes -> LockedOut=1 for 16 cycles, Validate during it causes no ShiftA; fourth attempt then counts from zero.
REQ-037 Open, ChangeCode, digits 5,6,7,8 -> ShiftB high for 4 Validates; re-entry 5,6,7,8 opens, 1,2,3,4 fails.
REQ-038 Enter after 2 digits -> CLEAR, fail count unchanged; fifth Validate after 4 digits -> DigitCount stays 4.
REQ-039 RST low asynchronously mid-ENTRY and mid-OPEN -> immediate CLEAR outputs, Unlocked=0.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock controller: state encoding,
// default parameter values and the timer width helper.
package lock_pkg;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StEntry,
        StCheck,
        StOpen,
        StNewCode,
        StLockout,
        StDuress
    } lock_state_e;

    localparam int unsigned DefDigits        = 4;
    localparam int unsigned DefMaxTries      = 3;
    localparam int unsigned DefUnlockCycles  = 50_000_000;
    localparam int unsigned DefLockoutCycles = 250_000_000;

    // Wide enough to hold (longest duration - 1).
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero,
// so loading N-1 on state entry gives a state lasting exactly N cycles.
module lock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/lock_controller.sv
// Control FSM of the combination lock: digit entry, code check, open window,
// code reprogramming, failed-attempt lockout and sticky duress alarm.
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS         = DefDigits,
    parameter int unsigned MAX_TRIES      = DefMaxTries,
    parameter int unsigned UNLOCK_CYCLES  = DefUnlockCycles,
    parameter int unsigned LOCKOUT_CYCLES = DefLockoutCycles
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Validate,
    input  logic                         Enter,
    input  logic                         ChangeCode,
    input  logic                         Pass,
    input  logic                         Reverse,
    output logic                         ShiftA,
    output logic                         ShiftB,
    output logic                         RSTA,
    output logic                         Unlocked,
    output logic                         Alarm,
    output logic                         LockedOut,
    output logic [$clog2(DIGITS+1)-1:0]  DigitCount
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned FW = $clog2(MAX_TRIES + 1);
    localparam int unsigned TW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

    localparam logic [CW-1:0] FullCount   = CW'(DIGITS);
    localparam logic [FW-1:0] TriesLimit  = FW'(MAX_TRIES);
    localparam logic [TW-1:0] UnlockLoad  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LockoutLoad = TW'(LOCKOUT_CYCLES - 1);

    lock_state_e   r_state, w_state_next;
    logic [CW-1:0] r_digit_count, w_digit_count_next;
    logic [FW-1:0] r_fail_count, w_fail_count_next;
    logic          r_alarm, w_alarm_next;
    logic          w_timer_load;
    logic [TW-1:0] w_timer_value;
    logic          w_timer_expired;
    logic          w_digits_full;

    assign w_digits_full = (r_digit_count == FullCount);

    lock_timer #(
        .WIDTH (TW)
    ) u_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_load    (w_timer_load),
        .i_value   (w_timer_value),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= StClear;
            r_digit_count <= '0;
            r_fail_count  <= '0;
            r_alarm       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_digit_count <= w_digit_count_next;
            r_fail_count  <= w_fail_count_next;
            r_alarm       <= w_alarm_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_digit_count_next = r_digit_count;
        w_fail_count_next  = r_fail_count;
        w_alarm_next       = r_alarm;
        w_timer_load       = 1'b0;
        w_timer_value      = UnlockLoad;
        unique case (r_state)
            StClear: begin
                w_digit_count_next = '0;
                w_state_next       = StIdle;
            end
            StIdle, StEntry: begin
                if (Validate && !w_digits_full) begin
                    w_digit_count_next = r_digit_count + 1'b1;
                    w_state_next       = StEntry;
                end
                // Enter is judged on the count held at the start of the cycle.
                if (Enter) begin
                    w_state_next = w_digits_full ? StCheck : StClear;
                end
            end
            StCheck: begin
                if (Pass) begin
                    w_fail_count_next = '0;
                    w_timer_load      = 1'b1;
                    w_state_next      = StOpen;
                end else if (Reverse) begin
                    w_fail_count_next = '0;
                    w_alarm_next      = 1'b1;
                    w_timer_load      = 1'b1;
                    w_state_next      = StDuress;
                end else begin
                    w_fail_count_next = r_fail_count + 1'b1;
                    if (w_fail_count_next >= TriesLimit) begin
                        w_timer_load  = 1'b1;
                        w_timer_value = LockoutLoad;
                        w_state_next  = StLockout;
                    end else begin
                        w_state_next  = StClear;
                    end
                end
            end
            StOpen: begin
                if (w_timer_expired) begin
                    w_state_next = StClear;
                end else if (ChangeCode) begin
                    w_digit_count_next = '0;
                    w_state_next       = StNewCode;
                end
            end
            StNewCode: begin
                if (w_digits_full) begin
                    w_state_next = StClear;
                end else if (Validate) begin
                    w_digit_count_next = r_digit_count + 1'b1;
                end
            end
            StLockout: begin
                if (w_timer_expired) begin
                    w_fail_count_next = '0;
                    w_state_next      = StClear;
                end
            end
            StDuress: begin
                if (w_timer_expired) begin
                    w_state_next = StClear;
                end
            end
        endcase
    end

    always_comb begin
        ShiftA    = 1'b0;
        ShiftB    = 1'b0;
        RSTA      = 1'b0;
        Unlocked  = 1'b0;
        LockedOut = 1'b0;
        unique case (r_state)
            StClear:          RSTA = 1'b1;
            StIdle, StEntry:  ShiftA = !w_digits_full;
            StCheck:          ;
            StOpen, StDuress: Unlocked = 1'b1;
            StNewCode: begin
                Unlocked = 1'b1;
                ShiftB   = !w_digits_full;
            end
            StLockout:        LockedOut = 1'b1;
        endcase
    end

    assign Alarm      = r_alarm;
    assign DigitCount = r_digit_count;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller with a behavioural entry/stored-code datapath
// and a queue of expected output vectors compared on the falling edge.
module tb_lock_controller;

    localparam logic [2:0] DCX = 3'd7;  // DigitCount don't-care marker

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Validate = 1'b0;
    logic       Enter = 1'b0;
    logic       ChangeCode = 1'b0;
    logic       Pass;
    logic       Reverse;
    logic       ShiftA, ShiftB, RSTA, Unlocked, Alarm, LockedOut;
    logic [2:0] DigitCount;
    logic [3:0] digit = 4'd0;

    logic [15:0] entry_reg = 16'h0000;
    logic [15:0] stored    = 16'h1234;
    logic        exp_alarm = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    typedef struct {
        logic       v;
        logic       e;
        logic       c;
        logic [3:0] d;
        logic [8:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    lock_controller #(
        .DIGITS         (4),
        .MAX_TRIES      (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Validate   (Validate),
        .Enter      (Enter),
        .ChangeCode (ChangeCode),
        .Pass       (Pass),
        .Reverse    (Reverse),
        .ShiftA     (ShiftA),
        .ShiftB     (ShiftB),
        .RSTA       (RSTA),
        .Unlocked   (Unlocked),
        .Alarm      (Alarm),
        .LockedOut  (LockedOut),
        .DigitCount (DigitCount)
    );

    always #5 CLK = ~CLK;

    // Datapath model: entry register and stored code, both shifting in digits.
    always @(posedge CLK) begin
        if (RSTA) entry_reg <= 16'h0000;
        else if (ShiftA && Validate) entry_reg <= {entry_reg[11:0], digit};
        if (ShiftB && Validate) stored <= {stored[11:0], digit};
    end

    assign Pass    = (entry_reg == stored);
    assign Reverse = (entry_reg == {stored[3:0], stored[7:4], stored[11:8], stored[15:12]});

    function automatic logic [8:0] o(input logic sa, input logic sb, input logic rs,
                                     input logic un, input logic lk, input logic [2:0] dc);
        return {sa, sb, rs, un, 1'b0, lk, dc};
    endfunction

    task automatic cmp(input string name, input logic [8:0] exp);
        logic [8:0] act;
        logic [8:0] want;
        act  = {ShiftA, ShiftB, RSTA, Unlocked, Alarm, LockedOut, DigitCount};
        want = exp;
        if (want[2:0] == DCX) want[2:0] = act[2:0];
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: sa/sb/rsta/unl/alm/lko/dc got %b required %b", name, act, want);
        end
    endtask

    always @(negedge CLK) begin
        while (sbq.size() > 0) begin
            sb_t item;
            item = sbq.pop_front();
            cmp(item.name, item.exp);
        end
    end

    task automatic push_exp(input logic [8:0] exp, input string name);
        logic [8:0] e;
        e    = exp;
        e[4] = exp_alarm;
        sbq.push_back('{name, e});
    endtask

    task automatic step(input logic v, input logic e, input logic c, input logic [3:0] d,
                        input logic [8:0] exp, input string name);
        Validate   = v;
        Enter      = e;
        ChangeCode = c;
        digit      = d;
        @(posedge CLK);
        #1;
        Validate   = 1'b0;
        Enter      = 1'b0;
        ChangeCode = 1'b0;
        push_exp(exp, name);
    endtask

    // From IDLE: four digits then Enter, ending in CHECK.
    task automatic enter_code(input logic [15:0] code, input string name);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, code[15-4*i -: 4], o(i < 3, 0, 0, 0, 0, 3'(i + 1)),
                 {name, "/digit"});
        end
        step(0, 1, 0, 4'd0, o(0, 0, 0, 0, 0, 3'd4), {name, "/check"});
    endtask

    task automatic fail_attempt(input logic [15:0] code, input string name);
        enter_code(code, name);
        step(0, 0, 0, 4'd0, o(0, 0, 1, 0, 0, DCX), {name, "/clear"});
        step(0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), {name, "/idle"});
    endtask

    task automatic async_reset(input string name);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        cmp({name, "/immediate"}, o(0, 0, 1, 0, 0, 3'd0));
        @(posedge CLK);
        #1;
        RST       = 1'b1;
        exp_alarm = 1'b0;
        push_exp(o(0, 0, 1, 0, 0, 3'd0), {name, "/first_cycle"});
        step(0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), {name, "/idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Unlock with the stored code, including an ignored fifth digit.
        tbl.push_back('{0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), "idle"});
        tbl.push_back('{1, 0, 0, 4'd1, o(1, 0, 0, 0, 0, 3'd1), "digit1"});
        tbl.push_back('{1, 0, 0, 4'd2, o(1, 0, 0, 0, 0, 3'd2), "digit2"});
        tbl.push_back('{1, 0, 0, 4'd3, o(1, 0, 0, 0, 0, 3'd3), "digit3"});
        tbl.push_back('{1, 0, 0, 4'd4, o(0, 0, 0, 0, 0, 3'd4), "digit4"});
        tbl.push_back('{1, 0, 0, 4'd9, o(0, 0, 0, 0, 0, 3'd4), "fifth_digit_ignored"});
        tbl.push_back('{0, 1, 0, 4'd0, o(0, 0, 0, 0, 0, 3'd4), "check"});
        for (int i = 0; i < 8; i++) begin
            tbl.push_back('{0, 0, 0, 4'd0, o(0, 0, 0, 1, 0, 3'd4), "open_window"});
        end
        tbl.push_back('{0, 0, 0, 4'd0, o(0, 0, 1, 0, 0, DCX), "open_to_clear"});
        tbl.push_back('{0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), "back_to_idle"});

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        push_exp(o(0, 0, 1, 0, 0, 3'd0), "reset_clear");

        foreach (tbl[i]) step(tbl[i].v, tbl[i].e, tbl[i].c, tbl[i].d, tbl[i].exp, tbl[i].name);

        // Reversed code raises the sticky duress alarm.
        enter_code(16'h4321, "duress");
        exp_alarm = 1'b1;
        repeat (8) step(0, 0, 0, 4'd0, o(0, 0, 0, 1, 0, 3'd4), "duress_window");
        step(0, 0, 0, 4'd0, o(0, 0, 1, 0, 0, DCX), "duress_clear");
        step(0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), "alarm_held_idle");

        // Three wrong codes lock out for 16 cycles; digits are ignored meanwhile.
        fail_attempt(16'h1111, "wrong1");
        fail_attempt(16'h1111, "wrong2");
        enter_code(16'h1111, "wrong3");
        step(0, 0, 0, 4'd0, o(0, 0, 0, 0, 1, DCX), "lockout_enter");
        repeat (15) step(1, 0, 0, 4'd5, o(0, 0, 0, 0, 1, DCX), "lockout_hold");
        step(0, 0, 0, 4'd0, o(0, 0, 1, 0, 0, DCX), "lockout_clear");
        step(0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), "lockout_idle");
        fail_attempt(16'h1111, "after_lockout1");
        fail_attempt(16'h1111, "after_lockout2");

        // Open, then program 5678; Enter during programming is ignored.
        enter_code(16'h1234, "open_for_change");
        step(0, 0, 0, 4'd0, o(0, 0, 0, 1, 0, 3'd4), "opened");
        step(0, 0, 1, 4'd0, o(0, 1, 0, 1, 0, 3'd0), "newcode_enter");
        step(1, 0, 0, 4'd5, o(0, 1, 0, 1, 0, 3'd1), "newcode_d5");
        step(1, 1, 0, 4'd6, o(0, 1, 0, 1, 0, 3'd2), "newcode_d6");
        step(1, 0, 0, 4'd7, o(0, 1, 0, 1, 0, 3'd3), "newcode_d7");
        step(1, 0, 0, 4'd8, o(0, 0, 0, 1, 0, 3'd4), "newcode_d8");
        step(0, 0, 0, 4'd0, o(0, 0, 1, 0, 0, DCX), "newcode_clear");
        step(0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), "newcode_idle");
        fail_attempt(16'h1234, "old_code");
        enter_code(16'h5678, "new_code");
        step(0, 0, 0, 4'd0, o(0, 0, 0, 1, 0, 3'd4), "new_code_opens");

        async_reset("rst_mid_open");

        step(1, 0, 0, 4'd2, o(1, 0, 0, 0, 0, 3'd1), "partial_d1");
        step(1, 0, 0, 4'd3, o(1, 0, 0, 0, 0, 3'd2), "partial_d2");
        async_reset("rst_mid_entry");

        // Early Enter clears without counting a failure: two more wrongs stay
        // below the limit, the third locks out.
        step(1, 0, 0, 4'd2, o(1, 0, 0, 0, 0, 3'd1), "short_d1");
        step(1, 0, 0, 4'd3, o(1, 0, 0, 0, 0, 3'd2), "short_d2");
        step(0, 1, 0, 4'd0, o(0, 0, 1, 0, 0, DCX), "short_enter_clear");
        step(0, 0, 0, 4'd0, o(1, 0, 0, 0, 0, 3'd0), "short_idle");
        fail_attempt(16'h1111, "count_wrong1");
        fail_attempt(16'h1111, "count_wrong2");
        enter_code(16'h1111, "count_wrong3");
        step(0, 0, 0, 4'd0, o(0, 0, 0, 0, 1, DCX), "count_lockout");

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
